xadc_temp_bcd: RTL and testbench



---
 rtl/xadc_temp_bcd.sv | 150 +++++++++++++++
 tb/tb_xadc_temp_bcd.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/xadc_temp_bcd.sv
// XADC temperature code to packed-BCD tenths of a degree Celsius (scale, double-dabble, atomic load).
// Define XADC_TEMP_AVG_EN to average four accepted samples before each conversion.
module xadc_temp_bcd #(
   parameter int g_OFFSET_X10 = 2732
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_valid,
   input  logic [11:0] i_code,
   output logic        o_busy,
   output logic [15:0] o_display_buffer,
   output logic        o_update,
   output logic        o_underflow
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SCALE = 2'd1;
   localparam logic [1:0] CONV  = 2'd2;
   localparam logic [1:0] LOAD  = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [11:0] code_q, code_d;
   logic [11:0] bin_q, bin_d;
   logic [15:0] bcd_q, bcd_d;
   logic [3:0]  iter_q, iter_d;
   logic        unf_q, unf_d;
   logic [15:0] disp_q, disp_d;
   logic        upd_q, upd_d;
   logic        unfo_q, unfo_d;

`ifdef XADC_TEMP_AVG_EN
   logic [13:0] acc_q, acc_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [13:0] acc_sum;
   assign acc_sum = acc_q + 14'(i_code);
`endif

   // Rounded fixed-point scale: code * 5040 / 4096 gives tenths of a Kelvin.
   logic [24:0] prod_rnd;
   logic [24:0] p_full;
   logic        scale_neg;
   logic [11:0] scale_bin;
   assign prod_rnd  = 25'(code_q) * 25'd5040 + 25'd2048;
   assign p_full    = prod_rnd >> 12;
   assign scale_neg = p_full < 25'(g_OFFSET_X10);
   assign scale_bin = scale_neg ? 12'd0 : 12'(p_full - 25'(g_OFFSET_X10));

   logic [15:0] bcd_adj;
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_dabble
         assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ? bcd_q[gi*4 +: 4] + 4'd3
                                                                : bcd_q[gi*4 +: 4];
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      iter_d  = iter_q;
      unf_d   = unf_q;
      disp_d  = disp_q;
      upd_d   = 1'b0;
      unfo_d  = unfo_q;
`ifdef XADC_TEMP_AVG_EN
      acc_d   = acc_q;
      cnt_d   = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (i_valid) begin
`ifdef XADC_TEMP_AVG_EN
               if (cnt_q == 2'd3) begin
                  code_d  = 12'(acc_sum >> 2);
                  acc_d   = 14'd0;
                  cnt_d   = 2'd0;
                  state_d = SCALE;
               end else begin
                  acc_d = acc_sum;
                  cnt_d = cnt_q + 2'd1;
               end
`else
               code_d  = i_code;
               state_d = SCALE;
`endif
            end
         end
         SCALE: begin
            bin_d   = scale_bin;
            unf_d   = scale_neg;
            bcd_d   = 16'd0;
            iter_d  = 4'd0;
            state_d = CONV;
         end
         CONV: begin
            bcd_d  = 16'({bcd_adj, bin_q[11]});
            bin_d  = bin_q << 1;
            iter_d = iter_q + 4'd1;
            if (iter_q == 4'd11) state_d = LOAD;
         end
         LOAD: begin
            disp_d  = bcd_q;
            unfo_d  = unf_q;
            upd_d   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         code_q  <= 12'd0;
         bin_q   <= 12'd0;
         bcd_q   <= 16'd0;
         iter_q  <= 4'd0;
         unf_q   <= 1'b0;
         disp_q  <= 16'd0;
         upd_q   <= 1'b0;
         unfo_q  <= 1'b0;
`ifdef XADC_TEMP_AVG_EN
         acc_q   <= 14'd0;
         cnt_q   <= 2'd0;
`endif
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         iter_q  <= iter_d;
         unf_q   <= unf_d;
         disp_q  <= disp_d;
         upd_q   <= upd_d;
         unfo_q  <= unfo_d;
`ifdef XADC_TEMP_AVG_EN
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign o_busy           = (state_q != IDLE);
   assign o_display_buffer = disp_q;
   assign o_update         = upd_q;
   assign o_underflow      = unfo_q;

endmodule

// File: tb/tb_xadc_temp_bcd.sv
// Randomized scoreboard bench for xadc_temp_bcd; honours XADC_TEMP_AVG_EN like the design.
module tb_xadc_temp_bcd;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic [11:0] i_code = 12'd0;
   logic        o_busy;
   logic [15:0] o_display_buffer;
   logic        o_update;
   logic        o_underflow;

   xadc_temp_bcd #(.g_OFFSET_X10(2732)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_valid          (i_valid),
      .i_code           (i_code),
      .o_busy           (o_busy),
      .o_display_buffer (o_display_buffer),
      .o_update         (o_update),
      .o_underflow      (o_underflow)
   );

   always #5 clk = ~clk;

`ifdef XADC_TEMP_AVG_EN
   localparam int N_PER = 4;
`else
   localparam int N_PER = 1;
`endif

   typedef struct {
      logic [15:0] disp;
      logic        unf;
      int          at_edge;
   } exp_t;

   exp_t        sb[$];
   int          edge_n = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   int          next_free = 0;
   int          conv_start = -100;
   int          acc_sum = 0;
   int          acc_cnt = 0;
   logic [15:0] last_disp = 16'h0000;

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, req, edge_n);
   endtask

   // Reference: tenths of a Kelvin by rounded arithmetic, minus offset, split into decimal digits.
   function automatic logic [16:0] ref_model(input int code);
      int p, t;
      p = (code * 5040 + 2048) / 4096;
      t = p - 2732;
      if (t < 0) return {1'b1, 16'h0000};
      return {1'b0, 4'(t / 1000), 4'((t / 100) % 10), 4'((t / 10) % 10), 4'(t % 10)};
   endfunction

   // A strobe sampled at edge e is honoured only if no conversion is in flight.
   task automatic model_sample(input int e, input int code);
      logic [16:0] r;
      int c;
      if (e < next_free) return;
      c = code;
`ifdef XADC_TEMP_AVG_EN
      acc_sum += code;
      acc_cnt++;
      if (acc_cnt < 4) return;
      c = acc_sum / 4;
      acc_sum = 0;
      acc_cnt = 0;
`endif
      r = ref_model(c);
      sb.push_back('{disp: r[15:0], unf: r[16], at_edge: e + 14});
      conv_start = e;
      next_free  = e + 15;
   endtask

   task automatic model_reset();
      sb.delete();
      next_free  = 0;
      conv_start = -100;
      acc_sum    = 0;
      acc_cnt    = 0;
      last_disp  = 16'h0000;
   endtask

   task automatic drive(input logic v, input logic [11:0] c);
      @(negedge clk);
      i_valid = v;
      i_code  = c;
      if (v) model_sample(edge_n + 1, int'(c));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 12'($urandom_range(0, 4095)));
   endtask

   task automatic send_conv(input logic [11:0] c);
      for (int i = 0; i < N_PER; i++) drive(1'b1, c);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents an update.
   always @(negedge clk) begin
      if (rst_n) begin
         check("busy", 32'(o_busy), 32'((edge_n >= conv_start) && (edge_n < next_free - 1)));
         if (o_update) begin
            if (sb.size() == 0) begin
               check("unexpected_update", 32'(o_display_buffer), 32'hFFFF_FFFF);
            end else begin
               exp_t x;
               x = sb.pop_front();
               check("display", 32'(o_display_buffer), 32'(x.disp));
               check("underflow", 32'(o_underflow), 32'(x.unf));
               check("update_edge", 32'(edge_n), 32'(x.at_edge));
               last_disp = x.disp;
               $display("update edge %0d: display %h underflow %0b", edge_n, o_display_buffer, o_underflow);
            end
         end
      end
   end

   initial begin
      logic [11:0] pick [6];
      pick[0] = 12'd0;    pick[1] = 12'd2219; pick[2] = 12'd2220;
      pick[3] = 12'd2221; pick[4] = 12'd4095; pick[5] = 12'd2464;

      repeat (3) @(negedge clk);
      check("reset_display", 32'(o_display_buffer), 32'h0);
      check("reset_update", 32'(o_update), 32'h0);
      check("reset_underflow", 32'(o_underflow), 32'h0);
      check("reset_busy", 32'(o_busy), 32'h0);
      rst_n = 1'b1;
      idle(2);

      send_conv(12'd2464); idle(18);
      send_conv(12'd4095); idle(18);
      send_conv(12'd2220); idle(18);
      send_conv(12'd0);    idle(18);
      send_conv(12'd2464); idle(18);

      // Input changes mid-conversion must not disturb the held display.
      send_conv(12'd4095);
      for (int i = 0; i < 8; i++) drive(1'b0, 12'($urandom_range(0, 4095)));
      check("hold_until_load", 32'(o_display_buffer), 32'(last_disp));
      idle(12);

      for (int i = 0; i < 16; i++) drive(1'b1, (i == 0) ? 12'd2464 : 12'd4095);
      idle(20);

`ifdef XADC_TEMP_AVG_EN
      drive(1'b1, 12'd2464); idle(3);
      drive(1'b1, 12'd2464); idle(3);
      drive(1'b1, 12'd2464); idle(3);
      drive(1'b1, 12'd2468); idle(18);
`endif

      // Reset in the middle of a conversion: outputs clear at once, nothing loads later.
      send_conv(12'd4095);
      idle(5);
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      check("midreset_display", 32'(o_display_buffer), 32'h0);
      check("midreset_update", 32'(o_update), 32'h0);
      check("midreset_underflow", 32'(o_underflow), 32'h0);
      check("midreset_busy", 32'(o_busy), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(20);

      for (int i = 0; i < 400; i++) begin
         logic [11:0] c;
         c = ($urandom_range(0, 1) == 0) ? pick[$urandom_range(0, 5)] : 12'($urandom_range(0, 4095));
         drive(($urandom_range(0, 2) == 0), c);
      end
      idle(20);
      check("scoreboard_empty", 32'(sb.size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
